udp_srio_width_packer: RTL and testbench

- Single-clock, parametrised upsizer that packs RATIO narrow UDP-side stream beats (IN_W bits) into one wide SRIO-side beat (IN_W*RATIO bits).
- Forwards first/last/keep/length sideband and checks the byte count against the declared length.
- Sits after the UDP receive path and ahead of input_reader in the srio clock domain.
- Generalises the fixed 32-to-64 packing with any integer ratio, length checking and protocol-error reporting.

---
 rtl/srio_udp_pkg.sv | 26 ++
 rtl/udp_srio_width_packer_byte_len_checker.sv | 51 +++++
 rtl/udp_srio_width_packer.sv | 176 +++++++++++++++++
 tb/tb_udp_srio_width_packer.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/srio_udp_pkg.sv
// Shared types and helpers for the UDP-to-SRIO width packer.
// OUT_W/OUT_KEEP_W describe the default 32-to-64 configuration.
package srio_udp_pkg;

  localparam int DEF_IN_W   = 32;
  localparam int DEF_RATIO  = 2;
  localparam int OUT_W      = DEF_IN_W * DEF_RATIO;
  localparam int OUT_KEEP_W = OUT_W / 8;
  localparam int MAX_KEEP_W = 256;

  typedef enum logic {
    IDLE = 1'b0,
    PACK = 1'b1
  } pack_state_t;

  // Callers zero-extend their keep vector to MAX_KEEP_W bits.
  function automatic int popcount_keep(input logic [MAX_KEEP_W-1:0] keep);
    int n;
    n = 0;
    for (int i = 0; i < MAX_KEEP_W; i++) begin
      n += int'(keep[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/udp_srio_width_packer_byte_len_checker.sv
// Counts packet bytes (saturating), latches the declared length and flags
// a mismatch against the running total including the current beat.
module byte_len_checker
  import srio_udp_pkg::*;
#(
  parameter int KEEP_W = OUT_KEEP_W / DEF_RATIO,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              beat,
  input  logic [KEEP_W-1:0] keep,
  input  logic [LEN_W-1:0]  len_in,
  output logic [LEN_W-1:0]  len_cur,
  output logic              mismatch
);

  logic [LEN_W-1:0] cnt_reg;
  logic [LEN_W-1:0] cnt_next;
  logic [LEN_W-1:0] len_reg;
  logic [LEN_W-1:0] beat_bytes;
  logic [LEN_W:0]   sum;

  assign beat_bytes = LEN_W'(popcount_keep(MAX_KEEP_W'(keep)));
  assign sum        = {1'b0, cnt_reg} + {1'b0, beat_bytes};

  // A starting beat replaces whatever was counted before it.
  always_comb begin
    cnt_next = sum[LEN_W] ? '1 : sum[LEN_W-1:0];
    if (start) begin
      cnt_next = beat_bytes;
    end
  end

  assign len_cur  = start ? len_in : len_reg;
  assign mismatch = (cnt_next != len_cur);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_reg <= '0;
      len_reg <= '0;
    end else if (start) begin
      cnt_reg <= cnt_next;
      len_reg <= len_in;
    end else if (beat) begin
      cnt_reg <= cnt_next;
    end
  end

endmodule

// File: rtl/udp_srio_width_packer.sv
// Packs RATIO narrow UDP beats into one wide SRIO beat, earliest beat in the
// MSBs, with sideband forwarding, length checking and framing-error pulses.
module udp_srio_width_packer
  import srio_udp_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int RATIO = OUT_W / DEF_IN_W,
  parameter int LEN_W = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [IN_W-1:0]           data_in,
  input  logic                      data_valid_in,
  input  logic                      data_first_in,
  input  logic                      data_last_in,
  input  logic [IN_W/8-1:0]         data_keep_in,
  input  logic [LEN_W-1:0]          data_len_in,
  output logic                      data_ready_out,
  output logic [IN_W*RATIO-1:0]     srio_data_out,
  output logic                      srio_valid_out,
  input  logic                      srio_ready_in,
  output logic                      srio_first_out,
  output logic                      srio_last_out,
  output logic [IN_W*RATIO/8-1:0]   srio_keep_out,
  output logic [LEN_W-1:0]          srio_length_out,
  output logic                      len_err_out,
  output logic                      proto_err_out
);

  localparam int KW_IN = IN_W / 8;
  localparam int PW    = IN_W * RATIO;
  localparam int PKW   = PW / 8;
  localparam int SW    = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [SW-1:0] LAST_SLOT = SW'(RATIO - 1);

  pack_state_t    state_reg;
  pack_state_t    state_next;
  logic [SW-1:0]  slot_reg;
  logic [SW-1:0]  slot_wr;
  logic [PW-1:0]  acc_data_reg;
  logic [PKW-1:0] acc_keep_reg;
  logic           acc_first_reg;
  logic [PW-1:0]  merged_data;
  logic [PKW-1:0] merged_keep;
  logic           ready_en_reg;
  logic           accept;
  logic           start;
  logic           cont;
  logic           complete;
  logic           proto_err_next;
  logic [LEN_W-1:0] len_cur;
  logic           mismatch;

  // ready_en_reg keeps ready low until the first clock after reset release.
  assign data_ready_out = ready_en_reg && (!srio_valid_out || srio_ready_in);
  assign accept         = data_valid_in && data_ready_out;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    start          = 1'b0;
    cont           = 1'b0;
    proto_err_next = 1'b0;
    if (accept) begin
      case (state_reg)
        IDLE: begin
          if (data_first_in) begin
            start      = 1'b1;
            state_next = data_last_in ? IDLE : PACK;
          end else begin
            proto_err_next = 1'b1;
          end
        end
        PACK: begin
          // A new first beat abandons the partial packet and restarts.
          if (data_first_in) begin
            start          = 1'b1;
            proto_err_next = 1'b1;
          end else begin
            cont = 1'b1;
          end
          if (data_last_in) begin
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign slot_wr  = start ? '0 : slot_reg;
  assign complete = (start || cont) && (data_last_in || (slot_wr == LAST_SLOT));

  // Merged view = accumulator with the current beat dropped into its slot.
  for (genvar gi = 0; gi < RATIO; gi++) begin : g_slot
    localparam int DHI = PW - 1 - gi * IN_W;
    localparam int KHI = PKW - 1 - gi * KW_IN;
    logic hit;
    assign hit = (slot_wr == SW'(gi));
    assign merged_data[DHI -: IN_W]  = hit ? data_in
                                     : (start ? '0 : acc_data_reg[DHI -: IN_W]);
    assign merged_keep[KHI -: KW_IN] = hit ? data_keep_in
                                     : (start ? '0 : acc_keep_reg[KHI -: KW_IN]);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ready_en_reg  <= 1'b0;
      slot_reg      <= '0;
      acc_data_reg  <= '0;
      acc_keep_reg  <= '0;
      acc_first_reg <= 1'b0;
    end else begin
      ready_en_reg <= 1'b1;
      if (complete) begin
        slot_reg      <= '0;
        acc_data_reg  <= '0;
        acc_keep_reg  <= '0;
        acc_first_reg <= 1'b0;
      end else if (start || cont) begin
        slot_reg      <= slot_wr + SW'(1);
        acc_data_reg  <= merged_data;
        acc_keep_reg  <= merged_keep;
        acc_first_reg <= start || acc_first_reg;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      srio_valid_out  <= 1'b0;
      srio_data_out   <= '0;
      srio_keep_out   <= '0;
      srio_first_out  <= 1'b0;
      srio_last_out   <= 1'b0;
      srio_length_out <= '0;
      len_err_out     <= 1'b0;
      proto_err_out   <= 1'b0;
    end else begin
      if (complete) begin
        srio_valid_out  <= 1'b1;
        srio_data_out   <= merged_data;
        srio_keep_out   <= merged_keep;
        srio_first_out  <= start || acc_first_reg;
        srio_last_out   <= data_last_in;
        srio_length_out <= len_cur;
      end else if (srio_ready_in) begin
        srio_valid_out <= 1'b0;
      end
      len_err_out   <= complete && data_last_in && mismatch;
      proto_err_out <= proto_err_next;
    end
  end

  byte_len_checker #(
    .KEEP_W (KW_IN),
    .LEN_W  (LEN_W)
  ) u_len_chk (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .beat     (cont),
    .keep     (data_keep_in),
    .len_in   (data_len_in),
    .len_cur  (len_cur),
    .mismatch (mismatch)
  );

endmodule

// File: tb/tb_udp_srio_width_packer.sv
// Directed bench for the width packer: RATIO=2 (dut0), RATIO=4 (dut1) and
// RATIO=1 (dut2) share the input bus; each has its own valid/ready.
module tb_udp_srio_width_packer;

  typedef struct {
    logic [127:0] data;
    logic [15:0]  keep;
    logic         first;
    logic         last;
    logic [15:0]  len;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] din;
  logic [3:0]  kin;
  logic        fin, lin;
  logic [15:0] nin;
  logic [2:0]  vld, rdy_o, srdy;

  logic [63:0]  o0_data;  logic [7:0]  o0_keep; logic [15:0] o0_len;
  logic         o0_valid, o0_first, o0_last, o0_lerr, o0_perr;
  logic [127:0] o1_data;  logic [15:0] o1_keep; logic [15:0] o1_len;
  logic         o1_valid, o1_first, o1_last, o1_lerr, o1_perr;
  logic [31:0]  o2_data;  logic [3:0]  o2_keep; logic [15:0] o2_len;
  logic         o2_valid, o2_first, o2_last, o2_lerr, o2_perr;

  int tests_run = 0;
  int tests_failed = 0;
  int lerr0 = 0, lerr_last0 = 0, perr0 = 0, lerr1 = 0, lerr2 = 0;
  beat_t q0[$], q1[$], q2[$];
  logic         stall0 = 1'b0;
  logic [127:0] held0 = '0;

  always #5 clk = ~clk;

  udp_srio_width_packer #(.IN_W(32), .RATIO(2), .LEN_W(16)) dut0 (
    .clk(clk), .reset(reset), .data_in(din), .data_valid_in(vld[0]),
    .data_first_in(fin), .data_last_in(lin), .data_keep_in(kin), .data_len_in(nin),
    .data_ready_out(rdy_o[0]), .srio_data_out(o0_data), .srio_valid_out(o0_valid),
    .srio_ready_in(srdy[0]), .srio_first_out(o0_first), .srio_last_out(o0_last),
    .srio_keep_out(o0_keep), .srio_length_out(o0_len), .len_err_out(o0_lerr),
    .proto_err_out(o0_perr));

  udp_srio_width_packer #(.IN_W(32), .RATIO(4), .LEN_W(16)) dut1 (
    .clk(clk), .reset(reset), .data_in(din), .data_valid_in(vld[1]),
    .data_first_in(fin), .data_last_in(lin), .data_keep_in(kin), .data_len_in(nin),
    .data_ready_out(rdy_o[1]), .srio_data_out(o1_data), .srio_valid_out(o1_valid),
    .srio_ready_in(srdy[1]), .srio_first_out(o1_first), .srio_last_out(o1_last),
    .srio_keep_out(o1_keep), .srio_length_out(o1_len), .len_err_out(o1_lerr),
    .proto_err_out(o1_perr));

  udp_srio_width_packer #(.IN_W(32), .RATIO(1), .LEN_W(16)) dut2 (
    .clk(clk), .reset(reset), .data_in(din), .data_valid_in(vld[2]),
    .data_first_in(fin), .data_last_in(lin), .data_keep_in(kin), .data_len_in(nin),
    .data_ready_out(rdy_o[2]), .srio_data_out(o2_data), .srio_valid_out(o2_valid),
    .srio_ready_in(srdy[2]), .srio_first_out(o2_first), .srio_last_out(o2_last),
    .srio_keep_out(o2_keep), .srio_length_out(o2_len), .len_err_out(o2_lerr),
    .proto_err_out(o2_perr));

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Output monitors: one line per transferred beat; dut0 also checks hold-while-stalled.
  always @(negedge clk) begin
    if (o0_valid && srdy[0]) begin
      q0.push_back('{{64'h0, o0_data}, {8'h0, o0_keep}, o0_first, o0_last, o0_len});
      $display("[TB] dut0 beat data=%h keep=%h first=%0b last=%0b len=%0d",
               o0_data, o0_keep, o0_first, o0_last, o0_len);
    end
    if (o0_lerr) begin
      lerr0++;
      if (o0_valid && o0_last) lerr_last0++;
    end
    if (o0_perr) perr0++;
    if (stall0 && o0_valid)
      check("stall_hold", {38'h0, o0_data, o0_keep, o0_first, o0_last, o0_len}, held0);
    stall0 = o0_valid && !srdy[0];
    held0  = {38'h0, o0_data, o0_keep, o0_first, o0_last, o0_len};
  end

  always @(negedge clk) begin
    if (o1_valid && srdy[1]) begin
      q1.push_back('{o1_data, o1_keep, o1_first, o1_last, o1_len});
      $display("[TB] dut1 beat data=%h keep=%h first=%0b last=%0b len=%0d",
               o1_data, o1_keep, o1_first, o1_last, o1_len);
    end
    if (o1_lerr) lerr1++;
  end

  always @(negedge clk) begin
    if (o2_valid && srdy[2]) begin
      q2.push_back('{{96'h0, o2_data}, {12'h0, o2_keep}, o2_first, o2_last, o2_len});
      $display("[TB] dut2 beat data=%h keep=%h first=%0b last=%0b len=%0d",
               o2_data, o2_keep, o2_first, o2_last, o2_len);
    end
    if (o2_lerr) lerr2++;
  end

  task automatic send(input int sel, input logic [31:0] d, input logic [3:0] k,
                      input logic f, input logic l, input logic [15:0] n);
    bit ok;
    ok  = 1'b0;
    din = d; kin = k; fin = f; lin = l; nin = n;
    vld = '0;
    vld[sel] = 1'b1;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (rdy_o[sel]) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
        break;
      end
    end
    vld = '0;
    if (!ok) check("send_timeout", 1'b0, 1'b1);
  endtask

  task automatic settle();
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic expect_beat(input int sel, input string tag, input logic [127:0] d,
                             input logic [127:0] m, input logic [15:0] k,
                             input logic f, input logic l, input logic [15:0] n);
    beat_t b;
    int    sz;
    case (sel)
      0: sz = q0.size();
      1: sz = q1.size();
      default: sz = q2.size();
    endcase
    check({tag, "_present"}, sz > 0, 1'b1);
    if (sz == 0) return;
    case (sel)
      0: b = q0.pop_front();
      1: b = q1.pop_front();
      default: b = q2.pop_front();
    endcase
    check({tag, "_data"},  b.data & m, d & m);
    check({tag, "_keep"},  b.keep, k);
    check({tag, "_first"}, b.first, f);
    check({tag, "_last"},  b.last, l);
    check({tag, "_len"},   b.len, n);
  endtask

  task automatic pulse_reset();
    #3 reset = 1'b0;
    #1;
    check("rst_mid_valid0", o0_valid, 1'b0);
    check("rst_mid_valid1", o1_valid, 1'b0);
    check("rst_mid_valid2", o2_valid, 1'b0);
    check("rst_mid_ready", rdy_o, 3'b000);
    #9 reset = 1'b1;
  endtask

  localparam logic [127:0] M64 = {64'h0, {64{1'b1}}};
  localparam logic [127:0] MHI = {64'h0, 32'hFFFF_FFFF, 32'h0};

  initial begin
    int base_l, base_p;
    din = '0; kin = '0; fin = 1'b0; lin = 1'b0; nin = '0; vld = '0; srdy = 3'b111;
    #12;
    check("rst_valid0", o0_valid, 1'b0);
    check("rst_data0", o0_data, 64'h0);
    check("rst_flags0", {o0_first, o0_last, o0_lerr, o0_perr}, 4'h0);
    check("rst_ready_all", rdy_o, 3'b000);
    #5 reset = 1'b1;
    #1 check("ready_before_clk", rdy_o[0], 1'b0);
    @(posedge clk); #1;
    check("ready_after_clk", rdy_o, 3'b111);

    // Full 16-byte packet
    send(0, 32'h00010203, 4'hF, 1, 0, 16'd16);
    send(0, 32'h04050607, 4'hF, 0, 0, 16'd16);
    send(0, 32'h08090A0B, 4'hF, 0, 0, 16'd16);
    send(0, 32'h0C0D0E0F, 4'hF, 0, 1, 16'd16);
    settle();
    expect_beat(0, "p16_b0", 128'h0001020304050607, M64, 16'h00FF, 1, 0, 16'd16);
    expect_beat(0, "p16_b1", 128'h08090A0B0C0D0E0F, M64, 16'h00FF, 0, 1, 16'd16);
    check("p16_no_lerr", lerr0, 0);
    check("p16_no_perr", perr0, 0);

    // 10 bytes: partial last beat lands in the upper lane
    send(0, 32'h00010203, 4'hF, 1, 0, 16'd10);
    send(0, 32'h04050607, 4'hF, 0, 0, 16'd10);
    send(0, 32'h08090000, 4'hC, 0, 1, 16'd10);
    settle();
    expect_beat(0, "p10_b0", 128'h0001020304050607, M64, 16'h00FF, 1, 0, 16'd10);
    expect_beat(0, "p10_b1", 128'h0809000000000000, MHI, 16'h00C0, 0, 1, 16'd10);
    check("p10_no_lerr", lerr0, 0);

    // Declared 16 but only 12 bytes arrive
    send(0, 32'h11111111, 4'hF, 1, 0, 16'd16);
    send(0, 32'h22222222, 4'hF, 0, 0, 16'd16);
    send(0, 32'h33333333, 4'hF, 0, 1, 16'd16);
    settle();
    expect_beat(0, "lerr_b0", 128'h1111111122222222, M64, 16'h00FF, 1, 0, 16'd16);
    expect_beat(0, "lerr_b1", 128'h3333333300000000, MHI, 16'h00F0, 0, 1, 16'd16);
    check("lerr_once", lerr0, 1);
    check("lerr_with_last", lerr_last0, 1);

    // Downstream stall mid-packet
    srdy[0] = 1'b0;
    fork
      begin
        send(0, 32'h00010203, 4'hF, 1, 0, 16'd16);
        send(0, 32'h04050607, 4'hF, 0, 0, 16'd16);
        send(0, 32'h08090A0B, 4'hF, 0, 0, 16'd16);
        send(0, 32'h0C0D0E0F, 4'hF, 0, 1, 16'd16);
      end
      begin
        repeat (6) @(negedge clk);
        check("stall_ready", rdy_o[0], 1'b0);
        check("stall_valid", o0_valid, 1'b1);
        check("stall_data", o0_data, 64'h0001020304050607);
        @(posedge clk); #1;
        srdy[0] = 1'b1;
      end
    join
    settle();
    expect_beat(0, "stall_b0", 128'h0001020304050607, M64, 16'h00FF, 1, 0, 16'd16);
    expect_beat(0, "stall_b1", 128'h08090A0B0C0D0E0F, M64, 16'h00FF, 0, 1, 16'd16);
    check("stall_no_dup", q0.size(), 0);

    // Framing errors: restart inside a packet, stray beat in IDLE
    base_p = perr0;
    send(0, 32'h00010203, 4'hF, 1, 0, 16'd8);
    send(0, 32'hAABBCCDD, 4'hF, 1, 0, 16'd8);
    send(0, 32'h11223344, 4'hF, 0, 1, 16'd8);
    send(0, 32'h55555555, 4'hF, 0, 0, 16'd8);
    settle();
    expect_beat(0, "proto_pkt", 128'hAABBCCDD11223344, M64, 16'h00FF, 1, 1, 16'd8);
    check("proto_pulses", perr0 - base_p, 2);
    check("proto_stray_dropped", q0.size(), 0);

    // RATIO=2: reset while an output beat is stalled
    base_l = lerr0;
    srdy[0] = 1'b0;
    send(0, 32'h00010203, 4'hF, 1, 0, 16'd8);
    send(0, 32'h04050607, 4'hF, 0, 0, 16'd8);
    pulse_reset();
    srdy[0] = 1'b1;
    send(0, 32'hCAFEBABE, 4'hF, 1, 0, 16'd8);
    send(0, 32'h12345678, 4'hF, 0, 1, 16'd8);
    settle();
    expect_beat(0, "rst2_pkt", 128'hCAFEBABE12345678, M64, 16'h00FF, 1, 1, 16'd8);
    check("rst2_no_stale", q0.size(), 0);
    check("rst2_no_lerr", lerr0 - base_l, 0);

    // RATIO=4: full packet, then reset mid-packet and a short packet
    send(1, 32'h00010203, 4'hF, 1, 0, 16'd16);
    send(1, 32'h04050607, 4'hF, 0, 0, 16'd16);
    send(1, 32'h08090A0B, 4'hF, 0, 0, 16'd16);
    send(1, 32'h0C0D0E0F, 4'hF, 0, 1, 16'd16);
    settle();
    expect_beat(1, "r4_full", 128'h000102030405060708090A0B0C0D0E0F, '1, 16'hFFFF, 1, 1, 16'd16);
    send(1, 32'hAAAAAAAA, 4'hF, 1, 0, 16'd12);
    send(1, 32'hBBBBBBBB, 4'hF, 0, 0, 16'd12);
    pulse_reset();
    send(1, 32'h01010101, 4'hF, 1, 0, 16'd12);
    send(1, 32'h02020202, 4'hF, 0, 0, 16'd12);
    send(1, 32'h03030303, 4'hF, 0, 1, 16'd12);
    settle();
    expect_beat(1, "r4_short", 128'h010101010202020203030303_00000000,
                {{96{1'b1}}, 32'h0}, 16'hFFF0, 1, 1, 16'd12);
    check("r4_no_extra", q1.size(), 0);
    check("r4_no_lerr", lerr1, 0);

    // RATIO=1: reset during a stall, then pass-through
    srdy[2] = 1'b0;
    send(2, 32'hDEADBEEF, 4'hF, 1, 1, 16'd4);
    pulse_reset();
    srdy[2] = 1'b1;
    send(2, 32'h01234567, 4'hF, 1, 0, 16'd8);
    send(2, 32'h89ABCDEF, 4'hF, 0, 1, 16'd8);
    send(2, 32'hA1B2C300, 4'hE, 1, 1, 16'd3);
    settle();
    expect_beat(2, "r1_b0", 128'h01234567, '1, 16'h000F, 1, 0, 16'd8);
    expect_beat(2, "r1_b1", 128'h89ABCDEF, '1, 16'h000F, 0, 1, 16'd8);
    expect_beat(2, "r1_single", 128'hA1B2C300, '1, 16'h000E, 1, 1, 16'd3);
    check("r1_no_extra", q2.size(), 0);
    check("r1_no_lerr", lerr2, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
